// File: rtl/mux_lock_key_loader_pkg.sv
// Shared definitions for the MUX-lock key loader.
//   lock_state_e : controller states
//   FAIL_CNT_W   : width of the consecutive-failure counter
//   nchunk()     : number of data beats needed to fill a KEY_W-bit key
package lock_pkg;

  localparam int FAIL_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CHECK   = 3'd2,
    ACTIVE  = 3'd3,
    FAIL    = 3'd4,
    LOCKOUT = 3'd5
  } lock_state_e;

  function automatic int nchunk(input int key_w, input int chunk_w);
    return key_w / chunk_w;
  endfunction

endpackage

// File: rtl/mux_lock_key_loader_shadow.sv
// Shadow key assembly for the loader: beat counter, shadow register and
// running XOR fold of the data beats.
//   clk, rst_n   : clock, async active-low reset
//   clr          : zero counter, shadow and fold (start of a load)
//   beat_en      : accept beat_data as data beat number beat_idx
//   beat_data    : CHUNK_W-bit chunk
//   beat_idx     : number of data beats accepted so far
//   fold         : XOR of all accepted data beats
//   shadow       : assembled key, LSB chunk first
module lock_key_shadow #(
  parameter int KEY_W   = 64,
  parameter int CHUNK_W = 8,
  parameter int BW      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               beat_en,
  input  logic [CHUNK_W-1:0] beat_data,
  output logic [BW-1:0]      beat_idx,
  output logic [CHUNK_W-1:0] fold,
  output logic [KEY_W-1:0]   shadow
);
  import lock_pkg::*;

  localparam int NCHUNK = nchunk(KEY_W, CHUNK_W);

  logic [BW-1:0]      beat_idx_q, beat_idx_d;
  logic [CHUNK_W-1:0] fold_q, fold_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;

  always_comb begin
    beat_idx_d = beat_idx_q;
    fold_d     = fold_q;
    shadow_d   = shadow_q;
    if (clr) begin
      beat_idx_d = '0;
      fold_d     = '0;
      shadow_d   = '0;
    end else if (beat_en) begin
      // Constant-index slices keep the write decoder simple and lint-clean.
      for (int i = 0; i < NCHUNK; i++)
        if (beat_idx_q == BW'(i)) shadow_d[i*CHUNK_W +: CHUNK_W] = beat_data;
      fold_d     = fold_q ^ beat_data;
      beat_idx_d = beat_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx_q <= '0;
      fold_q     <= '0;
      shadow_q   <= '0;
    end else begin
      beat_idx_q <= beat_idx_d;
      fold_q     <= fold_d;
      shadow_q   <= shadow_d;
    end
  end

  assign beat_idx = beat_idx_q;
  assign fold     = fold_q;
  assign shadow   = shadow_q;

endmodule

// File: rtl/mux_lock_key_loader.sv
// Key-delivery controller for MUX-locked netlists. Receives the key as a
// chunked valid/ready stream followed by an XOR-fold checksum beat, and
// drives the verified key onto key_out. DECOY_KEY is driven whenever no
// verified key is active; MAX_FAIL failed loads lock the block until reset.
//   load_start                        : request a (re)load
//   key_in_valid/ready/data/last      : key stream, checksum beat has last=1
//   key_out, key_active               : registered key bus and its qualifier
//   key_error                         : one-cycle pulse per failed load
//   lockout, fail_cnt                 : sticky lockout, saturating fail count
module mux_lock_key_loader
  import lock_pkg::*;
#(
  parameter int               KEY_W     = 64,
  parameter int               CHUNK_W   = 8,
  parameter int               MAX_FAIL  = 3,
  parameter logic [KEY_W-1:0] DECOY_KEY = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  key_in_valid,
  output logic                  key_in_ready,
  input  logic [CHUNK_W-1:0]    key_in_data,
  input  logic                  key_in_last,
  output logic [KEY_W-1:0]      key_out,
  output logic                  key_active,
  output logic                  key_error,
  output logic                  lockout,
  output logic [FAIL_CNT_W-1:0] fail_cnt
);

  localparam int NCHUNK = nchunk(KEY_W, CHUNK_W);
  localparam int BW     = $clog2(NCHUNK + 1);

  if ((KEY_W % CHUNK_W) != 0 || MAX_FAIL < 1 || MAX_FAIL > 255) begin : g_bad_param
    $error("mux_lock_key_loader: KEY_W must be a multiple of CHUNK_W and MAX_FAIL in 1..255");
  end

  lock_state_e           state_q, state_d;
  logic [KEY_W-1:0]      key_out_q, key_out_d;
  logic                  key_active_q, key_active_d;
  logic                  key_error_q, key_error_d;
  logic                  lockout_q, lockout_d;
  logic                  ready_q, ready_d;
  logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CHUNK_W-1:0]    chk_q, chk_d;

  logic                  sh_clr, sh_en, hs;
  logic [BW-1:0]         beat_idx;
  logic [CHUNK_W-1:0]    fold;
  logic [KEY_W-1:0]      shadow;

  assign hs = key_in_valid && ready_q;

  lock_key_shadow #(.KEY_W(KEY_W), .CHUNK_W(CHUNK_W), .BW(BW)) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (sh_clr),
    .beat_en   (sh_en),
    .beat_data (key_in_data),
    .beat_idx  (beat_idx),
    .fold      (fold),
    .shadow    (shadow)
  );

  always_comb begin
    state_d      = state_q;
    key_out_d    = key_out_q;
    key_active_d = key_active_q;
    fail_cnt_d   = fail_cnt_q;
    chk_d        = chk_q;
    sh_clr       = 1'b0;
    sh_en        = 1'b0;
    case (state_q)
      IDLE: if (load_start) begin
        state_d = LOAD;
        sh_clr  = 1'b1;
      end
      LOAD: if (hs) begin
        if (beat_idx < BW'(NCHUNK)) begin
          if (key_in_last) state_d = FAIL;   // early last
          else             sh_en   = 1'b1;
        end else if (!key_in_last) begin
          state_d = FAIL;                    // missing last
        end else begin
          chk_d   = key_in_data;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (fold == chk_q) begin
          state_d    = ACTIVE;
          fail_cnt_d = '0;
        end else begin
          state_d    = FAIL;
        end
      end
      ACTIVE: begin
        // The key is published one edge after entering ACTIVE; a re-key
        // drops it to the decoy on the same edge the reload starts.
        if (load_start) begin
          state_d      = LOAD;
          sh_clr       = 1'b1;
          key_out_d    = DECOY_KEY;
          key_active_d = 1'b0;
        end else begin
          key_out_d    = shadow;
          key_active_d = 1'b1;
        end
      end
      FAIL: begin
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
        state_d      = (fail_cnt_d >= FAIL_CNT_W'(MAX_FAIL)) ? LOCKOUT : IDLE;
        key_out_d    = DECOY_KEY;
        key_active_d = 1'b0;
      end
      LOCKOUT: begin
        key_out_d    = DECOY_KEY;
        key_active_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    key_error_d = (state_d == FAIL);
    lockout_d   = lockout_q || (state_d == LOCKOUT);
    ready_d     = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      key_out_q    <= DECOY_KEY;
      key_active_q <= 1'b0;
      key_error_q  <= 1'b0;
      lockout_q    <= 1'b0;
      ready_q      <= 1'b0;
      fail_cnt_q   <= '0;
      chk_q        <= '0;
    end else begin
      state_q      <= state_d;
      key_out_q    <= key_out_d;
      key_active_q <= key_active_d;
      key_error_q  <= key_error_d;
      lockout_q    <= lockout_d;
      ready_q      <= ready_d;
      fail_cnt_q   <= fail_cnt_d;
      chk_q        <= chk_d;
    end
  end

  assign key_in_ready = ready_q;
  assign key_out      = key_out_q;
  assign key_active   = key_active_q;
  assign key_error    = key_error_q;
  assign lockout      = lockout_q;
  assign fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_mux_lock_key_loader.sv
module tb_mux_lock_key_loader;
  localparam int          KW    = 16;
  localparam int          CW    = 8;
  localparam logic [15:0] DECOY = 16'hD1C0;

  logic          clk, rst_n, load_start, key_in_valid, key_in_ready, key_in_last;
  logic [CW-1:0] key_in_data;
  logic [KW-1:0] key_out;
  logic          key_active, key_error, lockout;
  logic [7:0]    fail_cnt;

  typedef struct { logic ok; logic [KW-1:0] key; } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int exp_fail = 0;
  bit gaps = 0;

  mux_lock_key_loader #(.KEY_W(KW), .CHUNK_W(CW), .MAX_FAIL(3), .DECOY_KEY(DECOY)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .key_in_valid(key_in_valid),
    .key_in_ready(key_in_ready), .key_in_data(key_in_data), .key_in_last(key_in_last),
    .key_out(key_out), .key_active(key_active), .key_error(key_error),
    .lockout(lockout), .fail_cnt(fail_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 0; load_start = 0; key_in_valid = 0; key_in_data = '0; key_in_last = 0;
    exp_fail = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic start_load();
    load_start = 1; step(); load_start = 0;
  endtask

  // Holds a beat until the handshake edge (ready is registered, so sampling
  // it before the edge predicts acceptance), optional random idle gap first.
  task automatic send_beat(input logic [CW-1:0] d, input logic last);
    bit acc = 0;
    if (gaps) repeat ($urandom_range(0, 2)) step();
    key_in_valid = 1; key_in_data = d; key_in_last = last;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = key_in_ready;
      step();
    end
    key_in_valid = 0; key_in_last = 0;
    checks++;
    if (!acc) begin errors++; $display("FAIL beat_accept data=%h ready never seen", d); end
  endtask

  task automatic push_exp(input logic ok, input logic [KW-1:0] key);
    exp_t e; e.ok = ok; e.key = key; sb.push_back(e);
  endtask

  // Waits (bounded) for the load outcome and checks it against the scoreboard.
  task automatic check_result(input string name);
    exp_t e;
    bit seen = 0;
    e = sb.pop_front();
    for (int i = 0; i < 10 && !seen; i++) begin
      if (key_active || key_error) seen = 1; else step();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_timeout no key_active/key_error", name); return; end
    checks++;
    if (key_active !== e.ok) begin
      errors++; $display("FAIL %s_outcome got active=%b want %b", name, key_active, e.ok);
    end
    checks++;
    if (key_out !== (e.ok ? e.key : DECOY)) begin
      errors++; $display("FAIL %s_key got %h want %h", name, key_out, e.ok ? e.key : DECOY);
    end
    if (e.ok) exp_fail = 0;
    else begin
      step();
      if (exp_fail < 255) exp_fail++;
      checks++;
      if (key_error !== 1'b0) begin errors++; $display("FAIL %s_err_pulse got %b want 0", name, key_error); end
    end
    checks++;
    if (fail_cnt !== 8'(exp_fail)) begin
      errors++; $display("FAIL %s_fail_cnt got %0d want %0d", name, fail_cnt, exp_fail);
    end
  endtask

  task automatic load_key(input logic [7:0] d0, d1, cs, input logic l1, l2);
    start_load();
    send_beat(d0, 1'b0);
    send_beat(d1, l1);
    if (!l1) send_beat(cs, l2);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({key_out, key_in_ready, key_active, key_error, lockout, fail_cnt} !== {DECOY, 4'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_state got key=%h rdy=%b act=%b err=%b lock=%b cnt=%0d want %h/0/0/0/0/0",
               key_out, key_in_ready, key_active, key_error, lockout, fail_cnt, DECOY);
    end
  endtask

  task automatic test_good_load();
    apply_reset();
    push_exp(1'b1, 16'h3CA5);
    load_key(8'hA5, 8'h3C, 8'h99, 1'b0, 1'b1);   // now 1ns after checksum edge N
    checks++;
    if (key_active !== 1'b0) begin errors++; $display("FAIL good_lat_n1 got %b want 0", key_active); end
    step();
    checks++;
    if (key_active !== 1'b0 || key_out !== DECOY) begin
      errors++; $display("FAIL good_lat_n1 got act=%b key=%h want 0/%h", key_active, key_out, DECOY);
    end
    step();
    checks++;
    if (key_active !== 1'b1) begin errors++; $display("FAIL good_lat_n2 got %b want 1", key_active); end
    check_result("good");
  endtask

  task automatic test_bad_checksum();
    apply_reset();
    push_exp(1'b0, '0);
    load_key(8'hA5, 8'h3C, 8'h98, 1'b0, 1'b1);
    check_result("bad_cs");
    checks++;
    if (key_in_ready !== 1'b0 || lockout !== 1'b0) begin
      errors++; $display("FAIL bad_cs_idle got rdy=%b lock=%b want 0/0", key_in_ready, lockout);
    end
  endtask

  task automatic test_framing();
    apply_reset();
    push_exp(1'b0, '0);
    load_key(8'hA5, 8'h3C, 8'h00, 1'b1, 1'b0);   // early last on beat 1
    check_result("early_last");
    apply_reset();
    push_exp(1'b0, '0);
    load_key(8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0);   // missing last on beat 2
    check_result("missing_last");
  endtask

  task automatic test_lockout();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, '0);
      load_key(8'h01, 8'h02, 8'h00, 1'b0, 1'b1);
      check_result("lock_bad");
    end
    checks++;
    if (lockout !== 1'b1) begin errors++; $display("FAIL lockout_set got %b want 1", lockout); end
    start_load();
    key_in_valid = 1; key_in_data = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (key_in_ready !== 1'b0 || key_out !== DECOY || lockout !== 1'b1) begin
        errors++;
        $display("FAIL lockout_hold got rdy=%b key=%h lock=%b want 0/%h/1", key_in_ready, key_out, lockout, DECOY);
      end
      step();
    end
    key_in_valid = 0;
  endtask

  task automatic test_rekey();
    apply_reset();
    push_exp(1'b1, 16'h3CA5);
    load_key(8'hA5, 8'h3C, 8'h99, 1'b0, 1'b1);
    check_result("rekey_first");
    start_load();
    checks++;
    if (key_out !== DECOY || key_active !== 1'b0) begin
      errors++; $display("FAIL rekey_decoy got key=%h act=%b want %h/0", key_out, key_active, DECOY);
    end
    push_exp(1'b1, 16'h2211);
    send_beat(8'h11, 1'b0);
    checks++;
    if (key_out !== DECOY) begin errors++; $display("FAIL rekey_no_old got %h want %h", key_out, DECOY); end
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b1);
    check_result("rekey_second");
  endtask

  task automatic test_reset_midload();
    apply_reset();
    start_load();
    send_beat(8'hA5, 1'b0);
    rst_n = 0; #2;
    checks++;
    if ({key_out, key_in_ready, key_active, key_error, lockout, fail_cnt} !== {DECOY, 4'b0, 8'd0}) begin
      errors++; $display("FAIL midload_reset got key=%h rdy=%b cnt=%0d want %h/0/0", key_out, key_in_ready, fail_cnt, DECOY);
    end
    step(); rst_n = 1; step(); step();
    checks++;
    if (fail_cnt !== 8'd0 || key_error !== 1'b0 || key_in_ready !== 1'b0) begin
      errors++; $display("FAIL midload_after got cnt=%0d err=%b rdy=%b want 0/0/0", fail_cnt, key_error, key_in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d0, d1;
    apply_reset();
    gaps = 1;
    push_exp(1'b1, 16'h3CA5);
    load_key(8'hA5, 8'h3C, 8'h99, 1'b0, 1'b1);
    check_result("gap_fixed");
    for (int n = 0; n < 4; n++) begin
      d0 = 8'($urandom); d1 = 8'($urandom);
      push_exp(1'b1, {d1, d0});
      load_key(d0, d1, d0 ^ d1, 1'b0, 1'b1);
      check_result("gap_rand");
    end
    gaps = 0;
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_framing();
    test_lockout();
    test_rekey();
    test_reset_midload();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule
